traj_host_driver: RTL and testbench
===================================

TRAJ_HOST_DRIVER -- requirements
Module: traj_host_driver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum cycles spent in any wait state before aborting.
REQ-002 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: request one calculation; sampled only while ready=1.
REQ-005 SHALL have port velocity, input, 8: launch velocity; captured when start is accepted.
REQ-006 SHALL have port angle, input, 8: launch angle; captured when start is accepted.
REQ-007 SHALL have port ready, output, 1: 1 only in IDLE.
REQ-008 SHALL have port res_valid, output, 1: one-cycle pulse when range is valid.
REQ-009 SHALL have port range, output, 16: assembled result {hi,lo}; holds until the next res_valid.
REQ-010 SHALL have port timeout, output, 1: one-cycle pulse on abort.
REQ-011 SHALL have port ui_in, output, 8: data byte driven to the calculator.
REQ-012 SHALL have port uio_in, output, 8: control to the calculator; [0] strobe, [2:1] field select (01 vel, 10 ang, 11 go), [3] res_ack, [7:4] tied to 0.
REQ-013 SHALL have port uo_out, input, 8: result byte from the calculator.
REQ-014 SHALL have port uio_out, input, 8: status from the calculator; [4] calc_res_valid; all other bits ignored.

Function
REQ-015 SHALL implement FSM states IDLE, WR_VEL, WR_ANG, WR_GO, WAIT_HI, ACK_HI, WAIT_LO, ACK_LO, DONE, ABORT.
REQ-016 start=1 in IDLE SHALL capture velocity and angle and enter WR_VEL on the next edge; start outside IDLE SHALL be ignored.
REQ-017 Each WR_* state SHALL last 2 cycles: cycle 1 drives ui_in=field value, select code and strobe=1; cycle 2 holds data and select with strobe=0.
REQ-018 WR_GO SHALL drive ui_in=0x00.
REQ-019 WR_VEL, WR_ANG and WR_GO SHALL run in that order, with no gap cycles.
REQ-020 WAIT_HI SHALL latch uo_out as the hi byte on the first cycle calc_res_valid=1, then enter ACK_HI.
REQ-021 ACK_HI SHALL drive res_ack=1 until calc_res_valid is sampled 0, then enter WAIT_LO (4-phase handshake).
REQ-022 WAIT_LO and ACK_LO SHALL behave like WAIT_HI and ACK_HI for the lo byte, then enter DONE.
REQ-023 DONE SHALL last one cycle: update range={hi,lo}, pulse res_valid, return to IDLE.
REQ-024 A wait counter SHALL clear on entry to WAIT_HI, ACK_HI, WAIT_LO and ACK_LO, and increment each cycle while in them.
REQ-025 When the wait counter reaches TIMEOUT_CYCLES-1 without the exit condition, the FSM SHALL enter ABORT.
REQ-026 ABORT SHALL last one cycle: pulse timeout, drop res_ack, leave range unchanged, return to IDLE.
REQ-027 If the exit condition and the timeout limit coincide, the exit condition SHALL win.
REQ-028 calc_res_valid already high on entry to WAIT_HI SHALL be accepted on the first cycle.
REQ-029 ui_in and uio_in SHALL be registered outputs; strobe and res_ack SHALL be glitch-free.
REQ-030 Latency with an immediately responding calculator SHALL be: start accept to first strobe 1 cycle; start accept to res_valid 6 cycles of writes plus the handshake cycles.

Reset
REQ-031 rst_n=0 SHALL asynchronously force state IDLE, ready=1, res_valid=0, timeout=0, range=0x0000, ui_in=0x00, uio_in=0x00, wait counter 0.
REQ-032 Reset mid-transaction SHALL abandon the transaction with no res_valid or timeout pulse; rst_n deassertion is synchronised by the integrator.

Structure
REQ-033 Package traj_link_pkg SHALL hold the state enum, the select codes (SEL_VEL=2'b01, SEL_ANG=2'b10, SEL_GO=2'b11) and the uio bit-position constants.
REQ-034 The wait counter SHALL be sub-module traj_timeout_ctr (inputs clear, enable; output expired; parameter TIMEOUT_CYCLES).
REQ-035 The FSM and the datapath SHALL stay in traj_host_driver.

Verification
REQ-036 The bench SHALL cover: start, velocity=0x32, angle=0x2D -> ui_in/select sequence 0x32/01, 0x2D/10, 0x00/11, each strobed exactly one cycle.
REQ-037 The bench SHALL cover: responder model returns 0x12 then 0x34 -> range=0x1234 with a single res_valid pulse; res_ack held until calc_res_valid falls each time.
REQ-038 The bench SHALL cover: no calc_res_valid with TIMEOUT_CYCLES=16 -> timeout pulses 16 cycles after WAIT_HI entry; range unchanged; ready=1 next cycle.
REQ-039 The bench SHALL cover: calc_res_valid stuck high in ACK_LO -> timeout; no res_valid.
REQ-040 The bench SHALL cover: rst_n low during ACK_HI -> all outputs at reset values immediately; next start completes normally.
REQ-041 The bench SHALL cover: start asserted continuously -> back-to-back transactions, each beginning the cycle after ready returns to 1.

Source files
------------

// File: rtl/traj_link_pkg.sv
// Shared types and constants for the trajectory calculator host link.
// State encoding, field select codes and uio bit positions.
package traj_link_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_VEL,
        WR_ANG,
        WR_GO,
        WAIT_HI,
        ACK_HI,
        WAIT_LO,
        ACK_LO,
        DONE,
        ABORT
    } state_t;

    localparam logic [1:0] SEL_VEL = 2'b01;
    localparam logic [1:0] SEL_ANG = 2'b10;
    localparam logic [1:0] SEL_GO  = 2'b11;

    localparam int UIO_STROBE     = 0;
    localparam int UIO_SEL_LSB    = 1;
    localparam int UIO_ACK        = 3;
    localparam int UIO_CALC_VALID = 4;

    function automatic logic is_wait(input state_t s);
        return (s == WAIT_HI) || (s == ACK_HI) ||
               (s == WAIT_LO) || (s == ACK_LO);
    endfunction

endpackage

// File: rtl/traj_timeout_ctr.sv
// Wait-state cycle counter for the host link.
// Flags expiry on the last allowed cycle of a wait state.
module traj_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/traj_host_driver.sv
// Host-side driver: writes velocity/angle/go to the calculator,
// then collects the two result bytes with 4-phase handshakes.
module traj_host_driver
    import traj_link_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  velocity,
    input  logic [7:0]  angle,
    output logic        ready,
    output logic        res_valid,
    output logic [15:0] range,
    output logic        timeout,
    output logic [7:0]  ui_in,
    output logic [7:0]  uio_in,
    input  logic [7:0]  uo_out,
    input  logic [7:0]  uio_out
);

    state_t     state, state_nx;
    logic       ph, ph_nx;
    logic [7:0] vel_q, ang_q, hi_q, lo_q;
    logic [7:0] ui_nx, uio_nx;
    logic       calc_valid;
    logic       ctr_clear, ctr_en, ctr_expired;
    logic       unused_status;

    assign calc_valid    = uio_out[UIO_CALC_VALID];
    assign unused_status = ^{uio_out[7:5], uio_out[3:0]};

    assign ctr_en    = is_wait(state);
    assign ctr_clear = is_wait(state_nx) && (state_nx != state);

    traj_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (ctr_clear),
        .enable (ctr_en),
        .expired(ctr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ph    <= 1'b0;
        end else begin
            state <= state_nx;
            ph    <= ph_nx;
        end
    end

    // ph marks the second (strobe-low) cycle of each write
    always_comb begin
        state_nx = state;
        ph_nx    = 1'b0;
        unique case (state)
            IDLE:    if (start) state_nx = WR_VEL;
            WR_VEL: begin
                ph_nx = !ph;
                if (ph) state_nx = WR_ANG;
            end
            WR_ANG: begin
                ph_nx = !ph;
                if (ph) state_nx = WR_GO;
            end
            WR_GO: begin
                ph_nx = !ph;
                if (ph) state_nx = WAIT_HI;
            end
            WAIT_HI: begin
                if (calc_valid)       state_nx = ACK_HI;
                else if (ctr_expired) state_nx = ABORT;
            end
            ACK_HI: begin
                if (!calc_valid)      state_nx = WAIT_LO;
                else if (ctr_expired) state_nx = ABORT;
            end
            WAIT_LO: begin
                if (calc_valid)       state_nx = ACK_LO;
                else if (ctr_expired) state_nx = ABORT;
            end
            ACK_LO: begin
                if (!calc_valid)      state_nx = DONE;
                else if (ctr_expired) state_nx = ABORT;
            end
            DONE:    state_nx = IDLE;
            ABORT:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // link outputs are precomputed from the next state and registered
    always_comb begin
        ready     = (state == IDLE);
        res_valid = (state == DONE);
        timeout   = (state == ABORT);
        ui_nx     = '0;
        uio_nx    = '0;
        unique case (state_nx)
            WR_VEL: begin
                ui_nx = (state == IDLE) ? velocity : vel_q;
                uio_nx[UIO_SEL_LSB +: 2] = SEL_VEL;
                uio_nx[UIO_STROBE]       = !ph_nx;
            end
            WR_ANG: begin
                ui_nx = ang_q;
                uio_nx[UIO_SEL_LSB +: 2] = SEL_ANG;
                uio_nx[UIO_STROBE]       = !ph_nx;
            end
            WR_GO: begin
                uio_nx[UIO_SEL_LSB +: 2] = SEL_GO;
                uio_nx[UIO_STROBE]       = !ph_nx;
            end
            ACK_HI:  uio_nx[UIO_ACK] = 1'b1;
            ACK_LO:  uio_nx[UIO_ACK] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vel_q  <= '0;
            ang_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            range  <= '0;
            ui_in  <= '0;
            uio_in <= '0;
        end else begin
            ui_in  <= ui_nx;
            uio_in <= uio_nx;
            if (state == IDLE && start) begin
                vel_q <= velocity;
                ang_q <= angle;
            end
            if (state == WAIT_HI && calc_valid) hi_q <= uo_out;
            if (state == WAIT_LO && calc_valid) lo_q <= uo_out;
            if (state_nx == DONE) range <= {hi_q, lo_q};
        end
    end

endmodule

// File: tb/tb_traj_host_driver.sv
// Scoreboard bench for traj_host_driver with a calculator responder.
// Stimulus pushes expected events; a negedge monitor pops and compares.
module tb_traj_host_driver;
    import traj_link_pkg::*;

    localparam int TO    = 16;
    localparam int EV_WR  = 0;
    localparam int EV_RES = 1;
    localparam int EV_TO  = 2;

    typedef struct {
        int          kind;
        logic [15:0] data;
        int          lat;
    } ev_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  velocity, angle;
    logic        ready, res_valid, timeout;
    logic [15:0] range;
    logic [7:0]  ui_in, uio_in, uo_out, uio_out;
    logic        calc_valid;

    assign uio_out = {3'b000, calc_valid, 4'b0000};

    traj_host_driver #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .velocity (velocity),
        .angle    (angle),
        .ready    (ready),
        .res_valid(res_valid),
        .range    (range),
        .timeout  (timeout),
        .ui_in    (ui_in),
        .uio_in   (uio_in),
        .uo_out   (uo_out),
        .uio_out  (uio_out)
    );

    ev_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  go_cyc = 0;
    int  last_ready_cyc = 0;
    int  done_cyc = -1;
    int  vel_cnt = 0;
    int  res_cnt = 0;
    int  resp_mode = 1;
    bit  b2b = 0;
    bit  hold_pend = 0;
    bit  rdy_pend = 0;
    logic [7:0] held_ui, held_uio;
    logic [7:0] hi_b, lo_b;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    function automatic void check(input string name,
                                  input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void pop_cmp(input int kind,
                                    input logic [15:0] data,
                                    input int lat);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: got kind %0d data %h, expected nothing",
                     kind, data);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.data !== data ||
                (e.lat >= 0 && e.lat != lat)) begin
                errors++;
                $display("FAIL sb: got kind %0d data %h lat %0d expected kind %0d data %h lat %0d",
                         kind, data, lat, e.kind, e.data, e.lat);
            end
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 0;
            rdy_pend  = 0;
        end else begin
            if (hold_pend) begin
                check("wr_hold_ui", 32'(ui_in), 32'(held_ui));
                check("wr_hold_uio", 32'(uio_in), 32'(held_uio & 8'hFE));
                hold_pend = 0;
            end
            if (rdy_pend) begin
                check("ready_after", 32'(ready), 32'd1);
                rdy_pend = 0;
            end
            if (uio_in[UIO_STROBE]) begin
                pop_cmp(EV_WR, {6'b0, uio_in[2:1], ui_in}, -1);
                if (uio_in[2:1] == SEL_VEL) begin
                    check("vel_after_idle", cyc - last_ready_cyc, 1);
                    if (b2b && done_cyc >= 0)
                        check("b2b_gap", cyc - done_cyc, 2);
                    vel_cnt++;
                end
                if (uio_in[2:1] == SEL_GO) go_cyc = cyc;
                hold_pend = 1;
                held_ui   = ui_in;
                held_uio  = uio_in;
            end
            if (res_valid) begin
                pop_cmp(EV_RES, range, -1);
                done_cyc = cyc;
                rdy_pend = 1;
                res_cnt++;
            end
            if (timeout) begin
                pop_cmp(EV_TO, range, cyc - go_cyc);
                rdy_pend = 1;
            end
            if (ready) last_ready_cyc = cyc;
        end
    end

    task automatic serve(input logic [7:0] b, input bit stuck);
        int n;
        repeat (2) @(negedge clk);
        uo_out     = b;
        calc_valid = 1'b1;
        n = 0;
        while (!uio_in[UIO_ACK] && n < 40 && rst_n) begin
            @(negedge clk);
            n++;
        end
        if (resp_mode == 3) begin
            n = 0;
            while (rst_n && n < 100) begin
                @(negedge clk);
                n++;
            end
            calc_valid = 1'b0;
        end else if (stuck) begin
            n = 0;
            while (!timeout && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("abort_ack", 32'(uio_in[UIO_ACK]), 32'd0);
            calc_valid = 1'b0;
        end else begin
            repeat (2) begin
                @(negedge clk);
                check("ack_hold", 32'(uio_in[UIO_ACK]), 32'd1);
            end
            calc_valid = 1'b0;
            @(negedge clk);
            check("ack_release", 32'(uio_in[UIO_ACK]), 32'd0);
        end
    endtask

    initial begin
        calc_valid = 1'b0;
        uo_out     = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && uio_in[UIO_STROBE] &&
                uio_in[2:1] == SEL_GO && resp_mode != 0) begin
                serve(hi_b, 1'b0);
                if (resp_mode != 3) serve(lo_b, resp_mode == 2);
            end
        end
    end

    task automatic push(input int kind, input logic [15:0] d, input int lat);
        ev_t e;
        e.kind = kind;
        e.data = d;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    task automatic push_wr(input logic [7:0] v, input logic [7:0] a);
        push(EV_WR, {6'b0, SEL_VEL, v}, -1);
        push(EV_WR, {6'b0, SEL_ANG, a}, -1);
        push(EV_WR, {6'b0, SEL_GO, 8'h00}, -1);
    endtask

    task automatic issue(input logic [7:0] v, input logic [7:0] a);
        start    = 1'b1;
        velocity = v;
        angle    = a;
        @(negedge clk);
        start    = 1'b0;
        velocity = 8'hFF;
        angle    = 8'hEE;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
        check({tag, "_range"}, 32'(range), 32'h0000);
        check({tag, "_ui_in"}, 32'(ui_in), 32'h00);
        check({tag, "_uio_in"}, 32'(uio_in), 32'h00);
    endtask

    initial begin
        int n;
        int base_vel;
        int base_res;
        rst_n    = 1'b0;
        start    = 1'b0;
        velocity = 8'h00;
        angle    = 8'h00;
        hi_b     = 8'h12;
        lo_b     = 8'h34;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);

        resp_mode = 1;
        push_wr(8'h32, 8'h2D);
        push(EV_RES, 16'h1234, -1);
        issue(8'h32, 8'h2D);
        drain();

        resp_mode = 0;
        push_wr(8'h11, 8'h22);
        push(EV_TO, 16'h1234, 2 + TO);
        issue(8'h11, 8'h22);
        drain();

        resp_mode = 2;
        hi_b = 8'h55;
        lo_b = 8'h66;
        push_wr(8'h01, 8'hFE);
        push(EV_TO, 16'h1234, -1);
        issue(8'h01, 8'hFE);
        drain();

        resp_mode = 3;
        hi_b = 8'h77;
        push_wr(8'h44, 8'h5A);
        issue(8'h44, 8'h5A);
        n = 0;
        while (!uio_in[UIO_ACK] && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("reach_ack_hi", 32'(uio_in[UIO_ACK]), 32'd1);
        #3 rst_n = 1'b0;
        #1 check_reset("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("sb_after_rst", sb.size(), 0);
        sb.delete();

        resp_mode = 1;
        hi_b = 8'hAB;
        lo_b = 8'hCD;
        push_wr(8'h60, 8'h0A);
        push(EV_RES, 16'hABCD, -1);
        issue(8'h60, 8'h0A);
        drain();

        hi_b     = 8'h56;
        lo_b     = 8'h78;
        done_cyc = -1;
        b2b      = 1;
        repeat (3) begin
            push_wr(8'h70, 8'h1E);
            push(EV_RES, 16'h5678, -1);
        end
        base_vel = vel_cnt;
        base_res = res_cnt;
        start    = 1'b1;
        velocity = 8'h70;
        angle    = 8'h1E;
        n = 0;
        while (vel_cnt < base_vel + 3 && n < 400) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        drain();
        b2b = 0;
        check("b2b_count", res_cnt - base_res, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
